// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath cells.
// Holds the serial FSM state encoding and the default operand width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin with borrow out.
// Counterpart of the full_adder cell used by the ripple adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// Operands and results move over valid/ready handshakes; final borrow is underflow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             underflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             underflow_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic             bout_s;

  full_subtractor u_fs (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bout_s)
  );

  assign accept_s = in_valid & in_ready_r;
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

  // Next-state selection for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand shifting, borrow chain, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      diff_r      <= '0;
      cnt_r       <= '0;
      borrow_r    <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so bit 0 lands at diff[0] last.
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          diff_r   <= {d_s, diff_r[WIDTH-1:1]};
          borrow_r <= bout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s) begin
            underflow_r <= bout_s;
          end
        end
        DONE: begin
          diff_r <= diff_r;
        end
        default: begin
          diff_r <= diff_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle model plus directed literal vectors.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         underflow;

  int n_pass  = 0;
  int n_total = 0;
  int results = 0;
  bit chk_en  = 1'b0;

  // Reference model: idle flag, compute countdown, presented result.
  bit           m_idle    = 1'b1;
  int           m_left    = 0;
  bit           m_present = 1'b0;
  logic [W-1:0] m_diff    = '0;
  bit           m_uf      = 1'b0;
  logic [W-1:0] pend_diff = '0;
  bit           pend_uf   = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_idle    <= 1'b1;
      m_left    <= 0;
      m_present <= 1'b0;
      m_diff    <= '0;
      m_uf      <= 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle    <= 1'b0;
        m_left    <= W;
        pend_diff <= a - b;
        pend_uf   <= (a < b);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_present <= 1'b1;
        m_diff    <= pend_diff;
        m_uf      <= pend_uf;
      end
    end else if (m_present && out_ready) begin
      m_present <= 1'b0;
      m_idle    <= 1'b1;
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_present});
      if (m_left == 0) begin
        check("diff", {28'd0, diff}, {28'd0, m_diff});
        check("underflow", {31'd0, underflow}, {31'd0, m_uf});
      end
      if (out_valid && out_ready) begin
        results++;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eu,
                       input int hold, input bit toggle);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #2;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (toggle) begin
        a        = W'($urandom);
        b        = W'($urandom);
        in_valid = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check("result_seen", {31'd0, seen}, 32'd1);
    check("lit_diff", {28'd0, diff}, {28'd0, ed});
    check("lit_uf", {31'd0, underflow}, {31'd0, eu});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_diff", {28'd0, diff}, {28'd0, ed});
      check("hold_uf", {31'd0, underflow}, {31'd0, eu});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
    check("valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    a        = 4'b0111;
    b        = 4'b0001;
    chk_en   = 1'b1;
    @(posedge clk);
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {28'd0, diff}, 32'd0);
    check("rst_uf", {31'd0, underflow}, 32'd0);

    do_op(4'b0101, 4'b0011, 4'b0010, 1'b0, 0, 1'b0);
    do_op(4'b0000, 4'b0001, 4'b1111, 1'b1, 0, 1'b0);
    do_op(4'b1010, 4'b1100, 4'b1110, 1'b1, 0, 1'b0);
    do_op(4'b1111, 4'b1111, 4'b0000, 1'b0, 0, 1'b0);
    do_op(4'b1111, 4'b0000, 4'b1111, 1'b0, 0, 1'b0);
    do_op(4'b1001, 4'b0011, 4'b0110, 1'b0, 5, 1'b0);
    do_op(4'b0011, 4'b1000, 4'b1011, 1'b1, 0, 1'b1);

    // Reset during the second RUN cycle discards the operation.
    @(posedge clk);
    #2;
    a        = 4'b1000;
    b        = 4'b0001;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff", {28'd0, diff}, 32'd0);
    check("midrst_uf", {31'd0, underflow}, 32'd0);
    rst = 1'b0;
    do_op(4'b0110, 4'b0010, 4'b0100, 1'b0, 0, 1'b0);

    // Exhaustive sweep at the minimum initiation interval.
    results   = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 256; i++) begin
      a        = W'(i >> 4);
      b        = W'(i);
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      repeat (W + 1) @(posedge clk);
      #2;
    end
    @(negedge clk);
    check("sweep_count", results, 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor that computes diff = a - b, one bit per clock, LSB first, and flags a final borrow as underflow.
- Operands are accepted and results are returned over valid/ready handshakes.
- It is the inverse arithmetic path to the team's ripple adder. It sits beside that adder in the ALU datapath and trades latency for a single full-subtractor cell.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a/b are presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff/underflow are valid.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- underflow  output  1  1 when a < b (final borrow out).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, in_ready=1, out_valid=0, diff=0, underflow=0, counter=0, borrow=0, operand shift registers=0. Reset takes priority over every other event, including mid-RUN and mid-DONE; any in-flight operation is discarded silently.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a and b into shift registers, clear borrow, clear counter, go to RUN.
  - diff/underflow keep their previous values until overwritten.
- RUN:
  - in_ready=0. Each cycle, the full_subtractor takes the LSBs of the shift registers plus the stored borrow.
  - The difference bit is shifted into diff from the MSB side, so after WIDTH shifts bit 0 is at diff[0].
  - Borrow register takes bout. Operand registers shift right by 1. Counter increments.
  - On the cycle where counter==WIDTH-1: underflow <= bout, go to DONE.
- DONE:
  - out_valid=1; diff and underflow are stable and must not change while out_valid=1.
  - On out_ready=1: go to IDLE (out_valid drops next cycle). in_ready stays 0 in DONE, so there is no same-cycle accept.
  - out_ready low: hold indefinitely.
- Latency: operands accepted at edge T; out_valid first high after edge T+WIDTH (i.e. WIDTH cycles). Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH compute, DONE, back to IDLE).
- Arithmetic: diff equals the low WIDTH bits of a + ~b + 1. underflow = (a < b) unsigned. No signed interpretation.
- a/b/in_valid are ignored outside IDLE; changes during RUN must not affect the result.
- in_valid with rst high the same cycle: not accepted.
- out_ready while not in DONE: ignored.

Decomposition:
- Shared package arith_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - DEFAULT_WIDTH=4.
- One sub-module: full_subtractor (a, b, bin -> d, bout).
  - d = a^b^bin.
  - bout = (~a&b) | (~(a^b)&bin).
  - It mirrors the existing full_adder cell and is exhaustively checkable on its own.

Test Plan:
- Basic subtraction: rst for 2 cycles, then a=0101, b=0011, in_valid pulse -> after 4 cycles out_valid=1, diff=0010, underflow=0; in_ready low throughout.
- Underflow: a=0000, b=0001 -> diff=1111, underflow=1. Also a=1010, b=1100 -> diff=1110, underflow=1.
- Equal and extreme operands: a=1111, b=1111 -> diff=0000, underflow=0. a=1111, b=0000 -> diff=1111, underflow=0.
- Backpressure and operand changes:
  - Hold out_ready=0 for 5 cycles after out_valid -> diff/underflow/out_valid stable.
  - Toggle a/b and in_valid during RUN -> result unchanged.
  - in_ready returns 1 one cycle after out_ready.
- Reset mid-operation: accept a=1000, b=0001, assert rst at the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, diff=0, underflow=0, in_ready=1.
  - Follow with a=0110, b=0010 -> diff=0100, underflow=0.
- Exhaustive WIDTH=4 sweep (all 256 pairs back-to-back, out_ready=1) -> every result matches the reference model (a-b) mod 16 with borrow = a<b. Each out_valid arrives exactly 4 cycles after its accept.
